// File: rtl/stopwatch_lap_timer.sv
// Min:sec stopwatch with up/down count, presets, lap capture and done/wrap pulses.
// Define STOPWATCH_HOURS_EN to add the hour field above the minutes.
module stopwatch_lap_timer #(
    parameter int TICK_DIV = 1,
    parameter int MIN_MAX  = 59,
    parameter int HOUR_W   = 5,
    parameter int LAP_W    = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              pause,
    input  logic              clear,
    input  logic              mode_down,
    input  logic              load,
    input  logic [5:0]        load_sec,
    input  logic [5:0]        load_min,
    input  logic              lap,
    output logic [5:0]        sec,
    output logic [5:0]        min,
    output logic [HOUR_W-1:0] hour,
    output logic              running,
    output logic              done,
    output logic              wrap,
    output logic [5:0]        lap_sec,
    output logic [5:0]        lap_min,
    output logic              lap_valid,
    output logic [LAP_W-1:0]  lap_count
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PLAST = PW'(TICK_DIV - 1);
    localparam logic [5:0] MMAX = 6'(MIN_MAX);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        PAUSE,
        DONE
    } state_t;

    state_t        state;
    logic [PW-1:0] presc;
    logic          dir_down;

    logic       sec_top, min_top, sec_bot, min_bot;
    logic       hr_top, hr_zero;
    logic       is_zero, reach0, wrap_all;
    logic       tick, lap_ok;
    logic [5:0] nsec, nmin;
    logic [5:0] ld_sec, ld_min;

`ifdef STOPWATCH_HOURS_EN
    logic [HOUR_W-1:0] hr_q;
    assign hour    = hr_q;
    assign hr_top  = &hr_q;
    assign hr_zero = (hr_q == '0);
`else
    assign hour    = '0;
    assign hr_top  = 1'b1;
    assign hr_zero = 1'b1;
`endif

    assign sec_top  = (sec == 6'd59);
    assign min_top  = (min == MMAX);
    assign sec_bot  = (sec == 6'd0);
    assign min_bot  = (min == 6'd0);
    assign is_zero  = sec_bot && min_bot && hr_zero;
    assign reach0   = (sec == 6'd1) && min_bot && hr_zero;
    assign wrap_all = sec_top && min_top && hr_top;

    // A down count parked at zero never ticks; it falls straight into DONE.
    assign tick = (state == RUN)
               && !(dir_down && is_zero)
               && (presc == PLAST);

    assign lap_ok = lap && (state == RUN || state == PAUSE);

    assign ld_sec = (load_sec > 6'd59) ? 6'd59 : load_sec;
    assign ld_min = (load_min > MMAX) ? MMAX : load_min;

    always_comb begin
        nsec = sec;
        nmin = min;
        if (!dir_down) begin
            nsec = sec_top ? 6'd0 : sec + 6'd1;
            if (sec_top)
                nmin = min_top ? 6'd0 : min + 6'd1;
        end else begin
            nsec = sec_bot ? 6'd59 : sec - 6'd1;
            if (sec_bot)
                nmin = min_bot ? MMAX : min - 6'd1;
        end
    end

`ifdef STOPWATCH_HOURS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hr_q <= '0;
        end else if (clear) begin
            hr_q <= '0;
        end else if (state == IDLE && load) begin
            hr_q <= '0;
        end else if (tick) begin
            if (!dir_down && sec_top && min_top)
                hr_q <= hr_q + 1'b1;
            else if (dir_down && sec_bot && min_bot)
                hr_q <= hr_q - 1'b1;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            presc     <= '0;
            dir_down  <= 1'b0;
            sec       <= '0;
            min       <= '0;
            running   <= 1'b0;
            done      <= 1'b0;
            wrap      <= 1'b0;
            lap_sec   <= '0;
            lap_min   <= '0;
            lap_valid <= 1'b0;
            lap_count <= '0;
        end else if (clear) begin
            state     <= IDLE;
            presc     <= '0;
            sec       <= '0;
            min       <= '0;
            running   <= 1'b0;
            done      <= 1'b0;
            wrap      <= 1'b0;
            lap_sec   <= '0;
            lap_min   <= '0;
            lap_valid <= 1'b0;
            lap_count <= '0;
        end else begin
            done <= 1'b0;
            wrap <= 1'b0;
            // Lap sees the pre-edge time, so a same-cycle tick is excluded.
            if (lap_ok) begin
                lap_sec   <= sec;
                lap_min   <= min;
                lap_valid <= 1'b1;
                if (lap_count != '1)
                    lap_count <= lap_count + 1'b1;
            end
            unique case (state)
                IDLE: begin
                    dir_down <= mode_down;
                    if (load) begin
                        sec <= ld_sec;
                        min <= ld_min;
                    end
                    if (start) begin
                        state   <= RUN;
                        running <= 1'b1;
                    end
                end
                RUN: begin
                    if (dir_down && is_zero) begin
                        state   <= DONE;
                        running <= 1'b0;
                        done    <= 1'b1;
                    end else begin
                        presc <= (presc == PLAST) ? '0 : presc + 1'b1;
                        if (tick) begin
                            sec  <= nsec;
                            min  <= nmin;
                            wrap <= !dir_down && wrap_all;
                        end
                        if (tick && dir_down && reach0) begin
                            state   <= DONE;
                            running <= 1'b0;
                            done    <= 1'b1;
                        end else if (pause) begin
                            state   <= PAUSE;
                            running <= 1'b0;
                        end
                    end
                end
                PAUSE: begin
                    if (start) begin
                        state   <= RUN;
                        running <= 1'b1;
                    end
                end
                DONE: begin
                end
                default: begin
                    state   <= IDLE;
                    running <= 1'b0;
                end
            endcase
        end
    end

endmodule
